// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file.
//   DEF_AW / DEF_DW / DEF_NRP : default address width, data width, read-port count
//   DEF_N                     : default register count (2**DEF_AW)
//   lane_lo()                 : low bit of lane p in a flattened bus of w-bit lanes
package regfile_pkg;

    localparam int unsigned DEF_AW  = 3;
    localparam int unsigned DEF_DW  = 16;
    localparam int unsigned DEF_NRP = 2;
    localparam int unsigned DEF_N   = 1 << DEF_AW;

    // Port p of a flattened bus occupies bits [lane_lo(p, w) +: w].
    function automatic int unsigned lane_lo(input int unsigned p, input int unsigned w);
        return p * w;
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port of regfile_mp_sb.
//   clk, rst_n     : clock, asynchronous active-low reset
//   rd_en, rd_addr : read strobe and address for this port
//   wr_en, wr_addr, wr_data : effective write of this cycle (for write-first bypass)
//   mem_data       : storage contents at rd_addr
//   busy_nxt       : next-state busy bit of the register at rd_addr
//   rd_data, rd_vld, rd_busy : registered outputs; data/busy hold while rd_en=0
module regfile_rd_port #(
    parameter int unsigned AW = 3,
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [DW-1:0] mem_data,
    input  logic          busy_nxt,
    output logic [DW-1:0] rd_data,
    output logic          rd_vld,
    output logic          rd_busy
);

    logic [DW-1:0] data_sel;

    // Write-first: a same-cycle write to the addressed register wins.
    always_comb begin
        data_sel = mem_data;
        if (wr_en && (wr_addr == rd_addr)) begin
            data_sel = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
            rd_vld  <= 1'b0;
            rd_busy <= 1'b0;
        end else begin
            rd_vld <= rd_en;
            if (rd_en) begin
                rd_data <= data_sel;
                rd_busy <= busy_nxt;
            end
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-read-port register file with registered reads, write-to-read bypass
// and a per-register busy scoreboard.
//   clk, rst_n          : clock, asynchronous active-low reset
//   wr_en/addr/data     : write port; a write clears the register's busy bit
//   rsv_en/addr         : reserve port; sets the busy bit (wins over a same-cycle clear)
//   rd_en/addr          : NRP read ports, addresses packed AW bits per port
//   rd_data/vld/busy    : registered per-port results, data packed DW bits per port
//   busy_vec            : scoreboard, one bit per register
// Build option: define REGFILE_ZERO_REG_EN to hardwire register 0 to zero
// (writes/reservations to address 0 are dropped, busy_vec[0] stays 0).
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int unsigned AW  = DEF_AW,
    parameter int unsigned DW  = DEF_DW,
    parameter int unsigned NRP = DEF_NRP
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [DW-1:0]       wr_data,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    input  logic [NRP-1:0]      rd_en,
    input  logic [NRP*AW-1:0]   rd_addr,
    output logic [NRP*DW-1:0]   rd_data,
    output logic [NRP-1:0]      rd_vld,
    output logic [NRP-1:0]      rd_busy,
    output logic [(1<<AW)-1:0]  busy_vec
);

    localparam int unsigned N = 1 << AW;

    logic [DW-1:0] mem [N];
    logic [N-1:0]  busy_nxt;
    logic          wr_eff;
    logic          rsv_eff;

    // With the zero register, accesses to address 0 are simply suppressed;
    // mem[0] then stays at its reset value and reads of it return 0.
    always_comb begin
`ifdef REGFILE_ZERO_REG_EN
        wr_eff  = wr_en  && (wr_addr  != '0);
        rsv_eff = rsv_en && (rsv_addr != '0);
`else
        wr_eff  = wr_en;
        rsv_eff = rsv_en;
`endif
    end

    // Clear first, then set: a same-cycle reservation belongs to a later producer.
    always_comb begin
        busy_nxt = busy_vec;
        if (wr_eff) begin
            busy_nxt[wr_addr] = 1'b0;
        end
        if (rsv_eff) begin
            busy_nxt[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N; i++) begin
                mem[i] <= '0;
            end
            busy_vec <= '0;
        end else begin
            if (wr_eff) begin
                mem[wr_addr] <= wr_data;
            end
            busy_vec <= busy_nxt;
        end
    end

    for (genvar p = 0; p < NRP; p++) begin : g_rd
        logic [AW-1:0] addr_p;

        always_comb begin
            addr_p = rd_addr[lane_lo(p, AW) +: AW];
        end

        regfile_rd_port #(
            .AW (AW),
            .DW (DW)
        ) u_port (
            .clk      (clk),
            .rst_n    (rst_n),
            .rd_en    (rd_en[p]),
            .rd_addr  (addr_p),
            .wr_en    (wr_eff),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .mem_data (mem[addr_p]),
            .busy_nxt (busy_nxt[addr_p]),
            .rd_data  (rd_data[lane_lo(p, DW) +: DW]),
            .rd_vld   (rd_vld[p]),
            .rd_busy  (rd_busy[p])
        );
    end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
Parametrised multi-read-port register file with registered reads, write-to-read bypass and a per-register busy scoreboard. It succeeds the single-read, combinational-read register file in the datapath. It sits between the controller (which reserves destination registers when an operation issues) and the execution units (which write results back). The scoreboard lets the controller detect read-after-write hazards without its own bookkeeping.

Parameters:
AW, 3, address width; register count N = 2**AW
DW, 16, data width in bits
NRP, 2, number of independent read ports (1..4)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write strobe
wr_addr  in  AW  write address
wr_data  in  DW  write data
rsv_en  in  1  reserve strobe: mark register pending
rsv_addr  in  AW  register to reserve
rd_en  in  NRP  per-port read strobe
rd_addr  in  NRP*AW  read addresses; port p occupies bits [p*AW +: AW]
rd_data  out  NRP*DW  registered read data; port p occupies bits [p*DW +: DW]
rd_vld  out  NRP  per-port read-data valid
rd_busy  out  NRP  per-port: the returned register is still pending
busy_vec  out  N  scoreboard; bit i is set when register i is pending

Behaviour:
- Reset: one clock, asynchronous, active-low. When rst_n is low, all N registers, busy_vec, rd_data, rd_vld and rd_busy are 0 immediately, independent of clk. Reset asserted mid-operation discards all pending reservations and reads.
- Write: on a clk edge with wr_en=1, mem[wr_addr] <= wr_data and busy_vec[wr_addr] is cleared. Write latency is one cycle.
- Reserve: on a clk edge with rsv_en=1, busy_vec[rsv_addr] is set.
- Write and reserve to the same address in the same cycle: the data is written and the busy bit ends at 1, because the reservation is for a later producer. Set takes priority over clear.
- Read: each port is independent with 1-cycle latency. On a clk edge with rd_en[p]=1, rd_data[p] gets the read value and rd_vld[p] is 1 for exactly the following cycle.
- Read source: if wr_en=1 and wr_addr equals rd_addr[p] in the same cycle, the port returns wr_data (write-first bypass). Otherwise it returns mem[rd_addr[p]].
- rd_busy[p] equals the next-state busy bit of the addressed register, i.e. after this cycle's clear and set. It is registered alongside rd_data.
- When rd_en[p]=0, rd_data[p] and rd_busy[p] hold their previous values and rd_vld[p] is 0.
- Multiple ports may read the same address in the same cycle. All of them receive identical data.
- Address wrap: addresses are exactly AW bits, so there is no out-of-range case.
- No internal state machine beyond storage. Reservation of an already-busy register is legal and idempotent. A write to a non-busy register is legal and leaves the busy bit clear.

Optional Feature:
REGFILE_ZERO_REG_EN
- Defined: register 0 is hardwired to zero. Writes to address 0 are ignored, reads of address 0 return 0 (including via bypass), busy_vec[0] is always 0, and reserving address 0 has no effect.
- Undefined: register 0 behaves as an ordinary register.

Decomposition:
- Shared package (regfile_pkg): default AW/DW/NRP constants, the derived N, and a helper function that slices the flattened port buses.
- One natural sub-module, regfile_rd_port: a single read port containing the bypass compare, the registered data, vld and busy outputs. It is instantiated NRP times with a generate loop.
- The storage array and scoreboard stay in the top module.

Test Plan:
- Reset: write 0xBEEF to r3, then pulse rst_n low between clock edges -> rd_data, rd_vld and busy_vec are 0 immediately; a later read of r3 returns 0x0000.
- Write then read: write 0x1234 to r5, read r5 on port 0 the next cycle -> one cycle later rd_data[0]=0x1234, rd_vld[0]=1 for exactly one cycle.
- Bypass: in the same cycle write 0xA5A5 to r2 and read r2 on both ports -> both ports return 0xA5A5 the next cycle.
- Scoreboard: reserve r6, then read r6 -> rd_busy=1. Write 0x0042 to r6, then read r6 -> busy_vec[6]=0 and rd_busy=0.
- Same-cycle reserve and write to r4 with 0x7777 -> mem[4]=0x7777 and busy_vec[4]=1. A simultaneous read of r4 returns 0x7777 with rd_busy=1.
- With REGFILE_ZERO_REG_EN: write 0xFFFF to r0 and reserve r0 -> a read returns 0x0000 and busy_vec[0]=0. Without the macro, the same stimulus returns 0xFFFF with busy_vec[0]=1.
